// File: rtl/systolic_tile_engine.sv
// Output-stationary NxN signed fixed-point matrix-multiply tile: C = A*B over K beats.
// Skews operands internally, flushes the array, then drains rounded/saturated rows of C.
module systolic_tile_engine #(
   parameter int DATA_BITS  = 16,
   parameter int FRAC_BITS  = 15,
   parameter int ACC_BITS   = 40,
   parameter int ARRAY_SIZE = 4,
   parameter int K_BITS     = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic [K_BITS-1:0]                k_len,
   output logic                             busy,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [ARRAY_SIZE*DATA_BITS-1:0]  a_col,
   input  logic [ARRAY_SIZE*DATA_BITS-1:0]  b_row,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [ARRAY_SIZE*DATA_BITS-1:0]  out_row,
   output logic [$clog2(ARRAY_SIZE):0]      out_row_idx,
   output logic                             out_last,
   output logic                             sat_flag
);
   localparam int N          = ARRAY_SIZE;
   localparam int IDX_W      = $clog2(N) + 1;
   localparam int FL_W       = $clog2(2 * N);
   localparam int FLUSH_LAST = (N > 1) ? 2 * (N - 1) - 1 : 0;
   localparam int PROD_W     = 2 * DATA_BITS;

   localparam logic signed [ACC_BITS-1:0] RND     = (ACC_BITS'(1) << FRAC_BITS) >> 1;
   localparam logic signed [ACC_BITS-1:0] SAT_MAX = (ACC_BITS'(1) << (DATA_BITS - 1)) - ACC_BITS'(1);
   localparam logic signed [ACC_BITS-1:0] SAT_MIN = ~SAT_MAX;
   localparam logic [IDX_W-1:0]           LAST_ROW = IDX_W'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_FLUSH, S_DRAIN} state_t;

   state_t              state, state_nxt;
   logic [K_BITS-1:0]   k_reg, k_cnt;
   logic [FL_W-1:0]     fl_cnt;
   logic [IDX_W-1:0]    row_idx;
   logic                clr, beat, tick, last_beat, flush_done, row_hs, row_clamp;

   logic [N-1:0][N-1:0][DATA_BITS-1:0] a_pipe, b_pipe;
   logic [N-1:0][N-1:0][ACC_BITS-1:0]  acc;
   logic [N-1:0][ACC_BITS-1:0]         row_acc;
   logic signed [ACC_BITS-1:0]         rounded;

   assign clr        = (state == S_IDLE) && start;
   assign beat       = (state == S_COMPUTE) && in_valid;
   assign tick       = beat || (state == S_FLUSH);
   assign last_beat  = beat && (k_cnt == k_reg - K_BITS'(1));
   assign flush_done = (state == S_FLUSH) && (fl_cnt == FL_W'(FLUSH_LAST));
   assign row_hs     = (state == S_DRAIN) && out_ready;

   assign busy        = (state != S_IDLE);
   assign in_ready    = (state == S_COMPUTE);
   assign out_valid   = (state == S_DRAIN);
   assign out_row_idx = row_idx;
   assign out_last    = (state == S_DRAIN) && (row_idx == LAST_ROW);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (start)      state_nxt = (k_len != '0) ? S_COMPUTE : S_DRAIN;
         S_COMPUTE: if (last_beat)  state_nxt = (N > 1) ? S_FLUSH : S_DRAIN;
         S_FLUSH:   if (flush_done) state_nxt = S_DRAIN;
         S_DRAIN:   if (row_hs && out_last) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         k_reg    <= '0;
         k_cnt    <= '0;
         fl_cnt   <= '0;
         row_idx  <= '0;
         sat_flag <= 1'b0;
      end else if (clr) begin
         k_reg    <= k_len;
         k_cnt    <= '0;
         fl_cnt   <= '0;
         row_idx  <= '0;
         sat_flag <= 1'b0;
      end else begin
         if (beat)               k_cnt  <= k_cnt + K_BITS'(1);
         if (state == S_FLUSH)   fl_cnt <= fl_cnt + FL_W'(1);
         if (row_hs) begin
            row_idx <= out_last ? '0 : row_idx + IDX_W'(1);
            if (row_clamp) sat_flag <= 1'b1;
         end
      end
   end

   // Row i of A and column i of B enter through i tick-gated delay stages; zeros during flush.
   for (genvar i = 0; i < N; i++) begin : g_skew
      logic [DATA_BITS-1:0] a_inj, b_inj;
      assign a_inj = (state == S_COMPUTE) ? a_col[i*DATA_BITS +: DATA_BITS] : '0;
      assign b_inj = (state == S_COMPUTE) ? b_row[i*DATA_BITS +: DATA_BITS] : '0;
      if (i == 0) begin : g_direct
         assign a_pipe[0][0] = a_inj;
         assign b_pipe[0][0] = b_inj;
      end else begin : g_delay
         logic [i-1:0][DATA_BITS-1:0] a_dly, b_dly;
         always_ff @(posedge clk or negedge reset) begin
            if (!reset || clr) begin
               a_dly <= '0;
               b_dly <= '0;
            end else if (tick) begin
               a_dly[0] <= a_inj;
               b_dly[0] <= b_inj;
               for (int d = 1; d < i; d++) begin
                  a_dly[d] <= a_dly[d-1];
                  b_dly[d] <= b_dly[d-1];
               end
            end
         end
         assign a_pipe[i][0] = a_dly[i-1];
         assign b_pipe[0][i] = b_dly[i-1];
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_pe
         logic signed [DATA_BITS-1:0] a_v, b_v;
         logic signed [PROD_W-1:0]    prod;
         logic signed [ACC_BITS-1:0]  acc_q;
         assign a_v  = a_pipe[i][j];
         assign b_v  = b_pipe[i][j];
         assign prod = PROD_W'(a_v) * PROD_W'(b_v);

         // NOTE: accumulators are plain flops, not a RAM, so they take the async reset like any state.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset || clr) acc_q <= '0;
            else if (tick)     acc_q <= acc_q + ACC_BITS'(prod);
         end
         assign acc[i][j] = acc_q;

         if (j < N - 1) begin : g_a_fwd
            logic [DATA_BITS-1:0] a_q;
            always_ff @(posedge clk or negedge reset) begin
               if (!reset || clr) a_q <= '0;
               else if (tick)     a_q <= a_pipe[i][j];
            end
            assign a_pipe[i][j+1] = a_q;
         end
         if (i < N - 1) begin : g_b_fwd
            logic [DATA_BITS-1:0] b_q;
            always_ff @(posedge clk or negedge reset) begin
               if (!reset || clr) b_q <= '0;
               else if (tick)     b_q <= b_pipe[i][j];
            end
            assign b_pipe[i+1][j] = b_q;
         end
      end
   end

   always_comb begin
      row_acc = '0;
      for (int r = 0; r < N; r++)
         if (row_idx == IDX_W'(r)) row_acc = acc[r];
   end

   // Round half up, then clamp to the DATA_BITS signed range.
   always_comb begin
      out_row   = '0;
      row_clamp = 1'b0;
      rounded   = '0;
      if (state == S_DRAIN) begin
         for (int j = 0; j < N; j++) begin
            rounded = ($signed(row_acc[j]) + RND) >>> FRAC_BITS;
            if (rounded > SAT_MAX) begin
               out_row[j*DATA_BITS +: DATA_BITS] = SAT_MAX[DATA_BITS-1:0];
               row_clamp = 1'b1;
            end else if (rounded < SAT_MIN) begin
               out_row[j*DATA_BITS +: DATA_BITS] = SAT_MIN[DATA_BITS-1:0];
               row_clamp = 1'b1;
            end else begin
               out_row[j*DATA_BITS +: DATA_BITS] = rounded[DATA_BITS-1:0];
            end
         end
      end
   end
endmodule

// File: tb/tb_systolic_tile_engine.sv
// Directed bench for systolic_tile_engine: default 4x4 Q1.15 instance plus a 1x1 instance.
module tb_systolic_tile_engine;
   logic        clk = 1'b0;
   logic        reset = 1'b0;

   logic        start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [7:0]  k_len = '0;
   logic [63:0] a_col = '0, b_row = '0;
   logic        busy, in_ready, out_valid, out_last, sat_flag;
   logic [63:0] out_row;
   logic [2:0]  out_row_idx;

   logic        start1 = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b0;
   logic [7:0]  k_len1 = '0;
   logic [15:0] a_col1 = '0, b_row1 = '0;
   logic        busy1, in_ready1, out_valid1, out_last1, sat_flag1;
   logic [15:0] out_row1;
   logic [0:0]  out_row_idx1;

   int n_checks = 0;
   int n_errors = 0;
   int last_wait;

   logic signed [15:0] a_mat [4][8];
   logic signed [15:0] b_mat [8][4];
   logic [63:0]        exp_row [4];

   systolic_tile_engine dut (
      .clk(clk), .reset(reset), .start(start), .k_len(k_len), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
      .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
      .out_row_idx(out_row_idx), .out_last(out_last), .sat_flag(sat_flag)
   );

   systolic_tile_engine #(.ARRAY_SIZE(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .k_len(k_len1), .busy(busy1),
      .in_valid(in_valid1), .in_ready(in_ready1), .a_col(a_col1), .b_row(b_row1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_row(out_row1),
      .out_row_idx(out_row_idx1), .out_last(out_last1), .sat_flag(sat_flag1)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic fill(input logic [15:0] a, input logic [15:0] b);
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 8; k++) begin
            a_mat[i][k] = a;
            b_mat[k][i] = b;
         end
   endtask

   task automatic expect_all(input logic [15:0] v);
      for (int r = 0; r < 4; r++) exp_row[r] = {4{v}};
   endtask

   // Reference: exact sum in 64 bits, round half up, clamp to Q1.15.
   function automatic logic [15:0] ref_elem(input int i, input int j, input int k_n);
      longint s;
      s = 0;
      for (int k = 0; k < k_n; k++) s += longint'(a_mat[i][k]) * longint'(b_mat[k][j]);
      s = (s + 64'sd16384) >>> 15;
      if (s > 32767)  return 16'h7FFF;
      if (s < -32768) return 16'h8000;
      return s[15:0];
   endfunction

   task automatic start_job(input int k_n);
      start = 1'b1;
      k_len = 8'(k_n);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input string tag, input int k_n, input bit gappy, input bit poke);
      int  beat, slot;
      bit  take;
      beat = 0;
      slot = 0;
      while (beat < k_n && slot < 200) begin
         take = !gappy || (slot % 3 == 0);
         if (poke && slot == 1) begin
            take  = 1'b0;
            start = 1'b1;
            k_len = 8'd1;
         end else begin
            start = 1'b0;
         end
         in_valid = take;
         for (int i = 0; i < 4; i++) begin
            a_col[i*16 +: 16] = a_mat[i][beat];
            b_row[i*16 +: 16] = b_mat[beat][i];
         end
         take = take && in_ready;
         @(negedge clk);
         if (take) beat++;
         slot++;
      end
      start    = 1'b0;
      in_valid = 1'b0;
      check({tag, " beats accepted"}, 64'(beat), 64'(k_n));
   endtask

   task automatic collect(input string tag, input int stall, input bit poke);
      int cyc;
      cyc = 0;
      out_ready = 1'b0;
      while (!out_valid && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      last_wait = cyc;
      check({tag, " out_valid"}, 64'(out_valid), 64'd1);
      for (int r = 0; r < 4; r++) begin
         for (int s = 0; s < stall; s++) begin
            start = poke;
            k_len = 8'd1;
            @(negedge clk);
            start = 1'b0;
            check({tag, " held row"}, out_row, exp_row[r]);
            check({tag, " held idx"}, 64'(out_row_idx), 64'(r));
         end
         check({tag, " row"},  out_row, exp_row[r]);
         check({tag, " idx"},  64'(out_row_idx), 64'(r));
         check({tag, " last"}, 64'(out_last), 64'(r == 3));
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end
      check({tag, " busy after drain"}, 64'(busy), 64'd0);
   endtask

   initial begin
      #3;
      check("reset busy",      64'(busy), 64'd0);
      check("reset in_ready",  64'(in_ready), 64'd0);
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset out_last",  64'(out_last), 64'd0);
      check("reset sat_flag",  64'(sat_flag), 64'd0);
      check("reset out_row",   out_row, 64'd0);
      check("reset row_idx",   64'(out_row_idx), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // 0.5 * 0.5 = 0.25 everywhere; 2(N-1) flush cycles before the first row.
      fill(16'h4000, 16'h4000);
      start_job(1);
      check("t1 busy", 64'(busy), 64'd1);
      send("t1", 1, 1'b0, 1'b0);
      expect_all(16'h2000);
      collect("t1", 0, 1'b0);
      check("t1 flush latency", 64'(last_wait), 64'd6);
      check("t1 sat_flag", 64'(sat_flag), 64'd0);

      // Positive saturation, then negative saturation with sat_flag cleared at start.
      fill(16'h7FFF, 16'h7FFF);
      start_job(4);
      send("t2a", 4, 1'b0, 1'b0);
      expect_all(16'h7FFF);
      collect("t2a", 0, 1'b0);
      check("t2a sat_flag", 64'(sat_flag), 64'd1);
      fill(16'h8000, 16'h7FFF);
      start_job(2);
      check("t2b sat cleared", 64'(sat_flag), 64'd0);
      send("t2b", 2, 1'b0, 1'b0);
      expect_all(16'h8000);
      collect("t2b", 0, 1'b0);
      check("t2b sat_flag", 64'(sat_flag), 64'd1);

      // Rounding: +0.5 LSB rounds up, -0.5 LSB rounds up to zero.
      fill(16'h0001, 16'h4000);
      start_job(1);
      send("t3a", 1, 1'b0, 1'b0);
      expect_all(16'h0001);
      collect("t3a", 0, 1'b0);
      fill(16'hFFFF, 16'h4000);
      start_job(1);
      send("t3b", 1, 1'b0, 1'b0);
      expect_all(16'h0000);
      collect("t3b", 0, 1'b0);
      check("t3b sat_flag", 64'(sat_flag), 64'd0);

      // Identity-like A with random B, gapped input and stalled output.
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 8; k++) a_mat[i][k] = (i == k) ? 16'h7FFF : 16'h0000;
      for (int k = 0; k < 8; k++)
         for (int j = 0; j < 4; j++) b_mat[k][j] = 16'($urandom);
      for (int r = 0; r < 4; r++)
         for (int j = 0; j < 4; j++) exp_row[r][j*16 +: 16] = ref_elem(r, j, 4);
      start_job(4);
      send("t4", 4, 1'b1, 1'b0);
      collect("t4", 3, 1'b0);

      // Asynchronous abort after two beats, then a clean job.
      fill(16'h7FFF, 16'h7FFF);
      start_job(4);
      send("t5", 2, 1'b0, 1'b0);
      check("t5 busy before abort", 64'(busy), 64'd1);
      check("t5 in_ready before abort", 64'(in_ready), 64'd1);
      #2 reset = 1'b0;
      #1;
      check("t5 abort busy",      64'(busy), 64'd0);
      check("t5 abort in_ready",  64'(in_ready), 64'd0);
      check("t5 abort out_valid", 64'(out_valid), 64'd0);
      check("t5 abort sat_flag",  64'(sat_flag), 64'd0);
      check("t5 abort out_row",   out_row, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      fill(16'h4000, 16'h4000);
      start_job(1);
      send("t5b", 1, 1'b0, 1'b0);
      expect_all(16'h2000);
      collect("t5b", 0, 1'b0);

      // K = 0 drains zero rows at once; start pulses mid-job are ignored.
      start_job(0);
      expect_all(16'h0000);
      collect("t6a", 0, 1'b0);
      check("t6a no compute", 64'(last_wait), 64'd0);
      fill(16'h4000, 16'h4000);
      start_job(2);
      send("t6b", 2, 1'b0, 1'b1);
      expect_all(16'h4000);
      collect("t6b", 1, 1'b1);

      // 1x1 array: DRAIN follows the last beat directly.
      start1 = 1'b1;
      k_len1 = 8'd3;
      @(negedge clk);
      start1 = 1'b0;
      check("n1 in_ready", 64'(in_ready1), 64'd1);
      in_valid1 = 1'b1;
      a_col1    = 16'h4000;
      b_row1    = 16'h4000;
      repeat (3) @(negedge clk);
      in_valid1 = 1'b0;
      check("n1 no flush",  64'(out_valid1), 64'd1);
      check("n1 row",       64'(out_row1), 64'h6000);
      check("n1 idx",       64'(out_row_idx1), 64'd0);
      check("n1 last",      64'(out_last1), 64'd1);
      check("n1 sat_flag",  64'(sat_flag1), 64'd0);
      out_ready1 = 1'b1;
      @(negedge clk);
      out_ready1 = 1'b0;
      check("n1 busy after drain", 64'(busy1), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/systolic_tile_engine.md
Name: systolic_tile_engine

Overview:
- Self-sequencing output-stationary N×N signed fixed-point matrix-multiply tile. It computes C = A·B over a programmable inner dimension K.
- The block owns input skewing, the flush phase and a row-wise result drain with valid/ready handshakes. Software only streams operands and collects rows.
- It succeeds the fixed Q1.15 array. Array size, fraction bits, accumulator width and K are parametrised, and rounding and a sticky saturation flag are added.
- It sits between the cluster operand buffers and the writeback path.

Parameters:
- DATA_BITS, 16: operand and result width, two's complement.
- FRAC_BITS, 15: fraction bits of operands and result. Range 0..DATA_BITS-1.
- ACC_BITS, 40: accumulator width. Must be ≥ 2*DATA_BITS + K_BITS.
- ARRAY_SIZE, 4: N, the number of rows and columns of PEs. Must be ≥ 1.
- K_BITS, 8: width of the inner-dimension length.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin job; sampled only in IDLE.
- k_len  in  K_BITS  inner dimension K; latched on start.
- busy  out  1  high in any state other than IDLE.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts an operand beat.
- a_col  in  N*DATA_BITS  column k of A; element i sits at [i*DATA_BITS +: DATA_BITS].
- b_row  in  N*DATA_BITS  row k of B; element j sits at [j*DATA_BITS +: DATA_BITS].
- out_valid  out  1  result row valid.
- out_ready  in  1  downstream accepts the row.
- out_row  out  N*DATA_BITS  row r of C; element j sits at [j*DATA_BITS +: DATA_BITS].
- out_row_idx  out  $clog2(N)+1  index r of the row currently presented.
- out_last  out  1  high with row N-1.
- sat_flag  out  1  sticky: some result of the current job saturated.

Behaviour:
- Reset (reset low, asynchronous):
  - state returns to IDLE.
  - All accumulators, skew registers and counters clear.
  - busy, in_ready, out_valid, out_last and sat_flag are 0; out_row and out_row_idx are 0.
  - Reset asserted mid-job aborts the job. No partial output is produced.
- FSM states: IDLE → COMPUTE → FLUSH → DRAIN → IDLE.
- IDLE:
  - start=1 clears all accumulators, clears sat_flag and latches k_len.
  - If k_len ≠ 0 the next state is COMPUTE; if k_len = 0 it is DRAIN, which outputs all-zero rows.
- COMPUTE:
  - in_ready = 1. A beat is accepted when in_valid && in_ready, and each accepted beat is one tick.
  - Operand skewing: a_col[i] enters row i through i stages of delay; b_row[j] enters column j through j stages of delay.
  - Pipeline flow: skew stages and PE a/b pipeline registers advance only on ticks. No tick means everything holds, so in_valid gaps are legal.
  - PE(i,j) update on each tick: acc += sign-extend(a*b), where a*b is the full 2*DATA_BITS signed product.
  - Operand k therefore reaches PE(i,j) on tick k+i+j.
  - After the K-th accepted beat: go to FLUSH if N > 1, otherwise go to DRAIN.
- FLUSH:
  - in_ready = 0. Exactly 2(N-1) ticks run, one per cycle, with zeros injected at the inputs.
  - Then go to DRAIN.
- DRAIN:
  - out_valid = 1. The presented row is r = out_row_idx, starting at 0.
  - Each element of the row is computed from its accumulator as follows:
    - Rounding: add 2^(FRAC_BITS-1) (skipped when FRAC_BITS = 0), then arithmetic right shift by FRAC_BITS. This is round-half-up toward +∞.
    - Saturation: clamp to [-2^(DATA_BITS-1), 2^(DATA_BITS-1)-1].
  - sat_flag is set if any element of a row clamps at the row's handshake. It stays set until the next start.
  - out_row, out_row_idx and out_last stay stable while out_valid && !out_ready.
  - Each handshake increments r. On the handshake where out_last=1 (r = N-1) the state goes to IDLE and busy drops the following cycle.
- Ignored and don't-care inputs:
  - start outside IDLE is ignored.
  - in_valid outside COMPUTE is ignored.
  - Operand content is don't-care while in_ready = 0.
- Accumulator overflow: prevented by the ACC_BITS constraint, so accumulators never wrap.
- Throughput: with no stalls, a job takes 1 + K + 2(N-1) + N cycles from start to the final handshake.

Test Plan:
- Defaults (N=4, Q1.15), K=1, all a = b = 0x4000 → every out_row element is 0x2000; sat_flag = 0; rows 0..3 appear in order; out_last is high on row 3 only.
- K=4, all a = b = 0x7FFF → every element is 0x7FFF and sat_flag = 1. Then K=2 with a = 0x8000, b = 0x7FFF → every element is 0x8000 and sat_flag = 1; it was cleared at start and set again.
- Rounding, K=1, a = 0x0001, b = 0x4000 → 0x0001. Same with a = 0xFFFF, b = 0x4000 → 0x0000.
- Identity check, K=4: A = diag(0x7FFF), B of random Q1.15 values, in_valid toggled 1,0,0,1,… and out_ready low for 3 cycles at each row → C equals B·0x7FFF rounded per element; out_row holds while stalled.
- Pull reset low mid-COMPUTE (after 2 beats) → busy, in_ready, out_valid and sat_flag are 0 immediately, with no clock needed. A following K=1 job produces correct results with no residue from the aborted job.
- start with k_len = 0 → 4 all-zero rows. start pulsed during COMPUTE and DRAIN is ignored (K unchanged, results correct). A job with N=1 (parameter override) skips FLUSH.
